// File: rtl/bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------------------------
// bus_xfer_sequencer
//
// Sequences register-to-register and immediate-to-register moves over the shared 8-bit dbus.
// It drives the active-low assert lines and the rising-edge trigger lines of the A/B/X/Q
// register block. Two requesters share the sequencer through a round-robin arbiter:
// 0 = microcode/fetch, 1 = debug/monitor.
//
// Each transfer runs IDLE -> DRIVE -> LATCH -> RELEASE -> IDLE:
//   DRIVE   the source drives dbus (assertBarA/X low, or imm on dbus) while data settles
//   LATCH   the source is still driven; the selected triggers are high for one cycle
//   RELEASE the triggers are low; the source stays driven for the hold time
//
// Parameters
//   SETTLE  cycles the source drives dbus before the trigger rises (1..7)
//   HOLD    cycles the source stays driven after the trigger falls (0..7, 0 acts as 1)
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       synchronous, active-high reset
//   req_valid   per-requester command valid
//   req_ready   per-requester accept strobe (one-cycle pulse)
//   req_cmd0/1  command {imm[7:0], src[1:0], dst[3:0]}
//               src: 00=A, 01=X, 10=IMM, 11=NONE; dst mask {Q,X,B,A}
//   dbus        shared data bus; driven here only for src=IMM
//   assertBarA  low = A drives dbus
//   assertBarX  low = X drives dbus
//   triggerA/B/X/Q  rising edge loads that register from dbus
//   busy        high while a transfer is in progress
//   done        one-cycle pulse at the end of a transfer
//   done_id     requester id of the finishing transfer (valid with done)
//   err         one-cycle pulse when a command is rejected
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------------------------

module bus_xfer_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned HOLD   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [13:0] req_cmd0,
    input  logic [13:0] req_cmd1,
    inout  wire  [7:0]  dbus,
    output logic        assertBarA,
    output logic        assertBarX,
    output logic        triggerA,
    output logic        triggerB,
    output logic        triggerX,
    output logic        triggerQ,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic        err
);

    // Source encoding.
    localparam logic [1:0] SrcA    = 2'b00;
    localparam logic [1:0] SrcX    = 2'b01;
    localparam logic [1:0] SrcImm  = 2'b10;
    localparam logic [1:0] SrcNone = 2'b11;

    // FSM states.
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDrive   = 2'd1;
    localparam logic [1:0] StLatch   = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    // A hold of zero still keeps the source driven for one cycle after the trigger falls,
    // so the register never sees data change on the same edge the trigger drops.
    localparam int unsigned HoldEff = (HOLD == 0) ? 1 : HOLD;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] cmd_q, cmd_d;
    logic        id_q, id_d;
    logic        rr_q, rr_d;      // preferred requester when both are valid
    logic        rej_q, rej_d;    // a rejected command was accepted last cycle

    // Registered outputs.
    logic [1:0]  ready_q, ready_d;
    logic        abar_a_q;
    logic        abar_x_q;
    logic        drive_imm_q;
    logic [3:0]  trig_q;
    logic        busy_q;
    logic        done_q, done_d;
    logic        done_id_q;
    logic        err_q, err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic        gnt_id;
    logic [13:0] gnt_cmd;

    always_comb begin
        if (&req_valid) begin
            gnt_id = rr_q;
        end else begin
            gnt_id = req_valid[1];
        end
        gnt_cmd = gnt_id ? req_cmd1 : req_cmd0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        rr_d    = rr_q;
        rej_d   = 1'b0;
        ready_d = 2'b00;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rej_q) begin
                    // The requester is still seeing its ready strobe this cycle and may
                    // hold valid; skip arbitration so the same command is not taken twice.
                    err_d = 1'b1;
                end else if (|req_valid) begin
                    ready_d[gnt_id] = 1'b1;
                    rr_d            = ~gnt_id;
                    id_d            = gnt_id;
                    cmd_d           = gnt_cmd;
                    if (gnt_cmd[5:4] == SrcNone && gnt_cmd[3:0] != 4'b0000) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d = StDrive;
                        cnt_d   = 3'(SETTLE);
                    end
                end
            end

            // The source is already driven in the grant cycle, so it gets SETTLE full
            // cycles beyond that before the trigger rises.
            StDrive: begin
                if (cnt_q == 3'd0) begin
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            StLatch: begin
                state_d = StRelease;
                cnt_d   = 3'(HoldEff - 1);
            end

            StRelease: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values follow directly from the next state, so every registered output
    // always agrees with state_q in the same cycle.
    logic       active_d;
    logic [1:0] src_d;

    always_comb begin
        active_d = (state_d != StIdle);
        src_d    = cmd_d[5:4];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            cmd_q       <= 14'd0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
            rej_q       <= 1'b0;
            ready_q     <= 2'b00;
            abar_a_q    <= 1'b1;
            abar_x_q    <= 1'b1;
            drive_imm_q <= 1'b0;
            trig_q      <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            rej_q       <= rej_d;
            ready_q     <= ready_d;
            abar_a_q    <= ~(active_d && src_d == SrcA);
            abar_x_q    <= ~(active_d && src_d == SrcX);
            drive_imm_q <= active_d && src_d == SrcImm;
            trig_q      <= (state_d == StLatch) ? cmd_d[3:0] : 4'b0000;
            busy_q      <= active_d;
            done_q      <= done_d;
            done_id_q   <= id_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dbus       = drive_imm_q ? cmd_q[13:6] : 8'bzzzz_zzzz;
    assign req_ready  = ready_q;
    assign assertBarA = abar_a_q;
    assign assertBarX = abar_x_q;
    assign triggerA   = trig_q[0];
    assign triggerB   = trig_q[1];
    assign triggerX   = trig_q[2];
    assign triggerQ   = trig_q[3];
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_bus_xfer_sequencer
//
// Scoreboard bench for bus_xfer_sequencer. Directed commands are queued per requester and the
// expected outcome of each transfer is pushed onto a scoreboard queue in the order the
// round-robin arbiter should serve them. A monitor models the A/B/X/Q register block on dbus,
// tracks triggers and drive cycles, and pops/compares whenever done or err pulses.
// ---------------------------------------------------------------------------------------------

module tb_bus_xfer_sequencer;

    localparam int unsigned SETTLE  = 1;
    localparam int unsigned HOLD    = 1;
    localparam int          LatTrig = SETTLE + 1;
    localparam int          LatDone = SETTLE + ((HOLD == 0) ? 1 : HOLD) + 2;

    localparam logic [1:0] SrcA    = 2'b00;
    localparam logic [1:0] SrcX    = 2'b01;
    localparam logic [1:0] SrcImm  = 2'b10;
    localparam logic [1:0] SrcNone = 2'b11;

    typedef struct packed {
        logic       is_err;
        logic       id;
        logic [1:0] src;
        logic [3:0] trig;   // triggers expected to rise
        logic [3:0] mask;   // registers to check afterwards
        logic [7:0] val;    // value those registers must hold
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [13:0] req_cmd0 = 14'd0;
    logic [13:0] req_cmd1 = 14'd0;
    wire  [7:0]  dbus;
    logic        assertBarA, assertBarX;
    logic        triggerA, triggerB, triggerX, triggerQ;
    logic        busy, done, done_id, err;

    // Register block model.
    logic [7:0] reg_a = 8'h5C;
    logic [7:0] reg_b = 8'h00;
    logic [7:0] reg_x = 8'h3C;
    logic [7:0] reg_q = 8'h00;

    assign dbus = (!assertBarA) ? reg_a : ((!assertBarX) ? reg_x : 8'hzz);

    bus_xfer_sequencer #(
        .SETTLE (SETTLE),
        .HOLD   (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd0   (req_cmd0),
        .req_cmd1   (req_cmd1),
        .dbus       (dbus),
        .assertBarA (assertBarA),
        .assertBarX (assertBarX),
        .triggerA   (triggerA),
        .triggerB   (triggerB),
        .triggerX   (triggerX),
        .triggerQ   (triggerQ),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;
    int viol    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [13:0] mk(input logic [7:0] imm, input logic [1:0] src,
                                       input logic [3:0] dst);
        return {imm, src, dst};
    endfunction

    exp_t        sb[$];
    logic [13:0] q0[$];
    logic [13:0] q1[$];

    task automatic push_exp(input logic is_err, input logic id, input logic [1:0] src,
                            input logic [3:0] trig, input logic [3:0] mask,
                            input logic [7:0] val);
        exp_t e;
        e.is_err = is_err;
        e.id     = id;
        e.src    = src;
        e.trig   = trig;
        e.mask   = mask;
        e.val    = val;
        sb.push_back(e);
    endtask

    task automatic check_regs(input exp_t e);
        if (e.mask[0]) check("reg_a", 32'(reg_a), 32'(e.val));
        if (e.mask[1]) check("reg_b", 32'(reg_b), 32'(e.val));
        if (e.mask[2]) check("reg_x", 32'(reg_x), 32'(e.val));
        if (e.mask[3]) check("reg_q", 32'(reg_q), 32'(e.val));
    endtask

    // Requester drivers: present the queue head, retire it when ready is seen.
    always @(negedge clk) begin
        logic [13:0] tmp;
        if (req_ready[0] && q0.size() > 0) tmp = q0.pop_front();
        if (req_ready[1] && q1.size() > 0) tmp = q1.pop_front();
        req_valid = {q1.size() > 0, q0.size() > 0};
        req_cmd0  = (q0.size() > 0) ? q0[0] : 14'd0;
        req_cmd1  = (q1.size() > 0) ? q1[0] : 14'd0;
    end

    // Monitor.
    logic [3:0] prev_trig      = 4'b0000;
    logic [3:0] trig_acc       = 4'b0000;
    logic [1:0] cur_src        = SrcNone;
    int         ready_cyc      = 0;
    int         first_trig_cyc = 0;
    int         drive_cnt      = 0;
    int         drv_run        = 0;

    always @(negedge clk) begin
        logic [3:0] trig;
        logic [3:0] rise;
        logic       driven;
        exp_t       e;
        trig      = {triggerQ, triggerX, triggerB, triggerA};
        rise      = trig & ~prev_trig;
        prev_trig = trig;
        if (reset) begin
            trig_acc  = 4'b0000;
            drive_cnt = 0;
            drv_run   = 0;
            cur_src   = SrcNone;
        end else begin
            if (|req_ready) begin
                ready_cyc = cyc;
                trig_acc  = 4'b0000;
                drive_cnt = 0;
                check("ready_onehot", 32'(req_ready == 2'b01 || req_ready == 2'b10), 32'd1);
                if (sb.size() > 0) begin
                    cur_src = sb[0].src;
                    check("grant_id", 32'(req_ready[1]), 32'(sb[0].id));
                end else begin
                    cur_src = SrcNone;
                end
            end

            if (rise[0]) reg_a = dbus;
            if (rise[1]) reg_b = dbus;
            if (rise[2]) reg_x = dbus;
            if (rise[3]) reg_q = dbus;
            if (|rise) begin
                if (trig_acc == 4'b0000) first_trig_cyc = cyc;
                trig_acc = trig_acc | rise;
                check("settle_before_trig", 32'(drv_run >= int'(SETTLE)), 32'd1);
            end

            if (!assertBarA && !assertBarX) viol++;
            if (!busy && (!assertBarA || !assertBarX)) viol++;
            if (busy && cur_src == SrcImm && (!assertBarA || !assertBarX)) viol++;
            driven  = !assertBarA || !assertBarX || (busy && cur_src == SrcImm);
            drv_run = driven ? drv_run + 1 : 0;
            if (!assertBarA || !assertBarX) drive_cnt++;

            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: done_id %0d, nothing outstanding", done_id);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", 32'(e.is_err), 32'd0);
                    check("done_id", 32'(done_id), 32'(e.id));
                    check("accept_to_done", 32'(cyc - ready_cyc), 32'(LatDone));
                    check("trig_mask", 32'(trig_acc), 32'(e.trig));
                    if (e.trig != 4'b0000)
                        check("accept_to_trig", 32'(first_trig_cyc - ready_cyc), 32'(LatTrig));
                    check("drive_cycles", 32'(drive_cnt),
                          32'((e.src == SrcA || e.src == SrcX) ? LatDone : 0));
                    check("done_gap", 32'({assertBarA, assertBarX, busy}), 32'(3'b110));
                    check_regs(e);
                end
            end

            if (err) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_err: err pulse, nothing outstanding");
                end else begin
                    e = sb.pop_front();
                    check("err_kind", 32'(e.is_err), 32'd1);
                    check("accept_to_err", 32'(cyc - ready_cyc), 32'd1);
                    check("err_no_trig", 32'(trig_acc), 32'd0);
                    check("err_no_busy", 32'(busy), 32'd0);
                    check_regs(e);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (i < 200 && (sb.size() != 0 || q0.size() != 0 || q1.size() != 0)) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  done_before;
        bit  seen;

        repeat (3) @(negedge clk);
        check("rst_bars", 32'({assertBarA, assertBarX}), 32'(2'b11));
        check("rst_trig", 32'({triggerQ, triggerX, triggerB, triggerA}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Both requesters contend: grants 0,1,0,1 and Q follows 11,22,11,22.
        push_exp(0, 0, SrcImm, 4'b1000, 4'b1000, 8'h11);
        push_exp(0, 1, SrcImm, 4'b1000, 4'b1000, 8'h22);
        push_exp(0, 0, SrcImm, 4'b1000, 4'b1000, 8'h11);
        push_exp(0, 1, SrcImm, 4'b1000, 4'b1000, 8'h22);
        repeat (2) q0.push_back(mk(8'h11, SrcImm, 4'b1000));
        repeat (2) q1.push_back(mk(8'h22, SrcImm, 4'b1000));
        wait_drain("alternate");

        // A -> B with A = 5C.
        push_exp(0, 0, SrcA, 4'b0010, 4'b0010, 8'h5C);
        q0.push_back(mk(8'h00, SrcA, 4'b0010));
        wait_drain("a_to_b");

        // IMM A5 into all four registers.
        push_exp(0, 1, SrcImm, 4'b1111, 4'b1111, 8'hA5);
        q1.push_back(mk(8'hA5, SrcImm, 4'b1111));
        wait_drain("imm_all");

        // NONE with a destination is rejected; X keeps A5.
        push_exp(1, 0, SrcNone, 4'b0000, 4'b0100, 8'hA5);
        q0.push_back(mk(8'h00, SrcNone, 4'b0100));
        wait_drain("reject");

        // Reject by req0 still moves the pointer, so req1 wins the next contention.
        push_exp(0, 1, SrcImm, 4'b0100, 4'b0100, 8'h44);
        push_exp(0, 0, SrcImm, 4'b0010, 4'b0010, 8'h33);
        q0.push_back(mk(8'h33, SrcImm, 4'b0010));
        q1.push_back(mk(8'h44, SrcImm, 4'b0100));
        wait_drain("rr_after_reject");

        // NONE with dst=0 is a no-op transfer.
        push_exp(0, 1, SrcNone, 4'b0000, 4'b0000, 8'h00);
        q1.push_back(mk(8'h00, SrcNone, 4'b0000));
        wait_drain("noop");

        // A -> A reloads its own value.
        push_exp(0, 0, SrcA, 4'b0001, 4'b0001, 8'hA5);
        q0.push_back(mk(8'h00, SrcA, 4'b0001));
        wait_drain("a_to_a");

        // Reset during LATCH of X -> A.
        q0.push_back(mk(8'h00, SrcX, 4'b0001));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (triggerA) seen = 1'b1;
        end
        check("rst_mid_latch_seen", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_bars", 32'({assertBarA, assertBarX}), 32'(2'b11));
        check("rst_mid_trig", 32'({triggerQ, triggerX, triggerB, triggerA}), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_reg_a", 32'(reg_a), 32'(8'h44));
        reset       = 1'b0;
        done_before = n_done;
        repeat (8) @(negedge clk);
        check("rst_mid_no_done", 32'(n_done - done_before), 32'd0);
        check("rst_mid_idle", 32'({busy, assertBarA, assertBarX}), 32'(3'b011));

        check("invariant_violations", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
